// File: rtl/cpt_updown_bcd_ndigits.sv
// Cascaded NB_DIGITS up/down counter, each digit modulo RADIX, with load, clear,
// wrap/saturate end-of-range handling, terminal count and sticky overflow.

// Checks that no digit of the count ever leaves the 0..RADIX-1 range.
module cpt_updown_bcd_ndigits_chk #(
   parameter int NB_DIGITS = 4,
   parameter int RADIX     = 10,
   parameter int DIGIT_W   = 4
) (
   input logic                           Clk,
   input logic                           Reset,
   input logic [NB_DIGITS*DIGIT_W-1:0]   Cpt
);

   // Digit range check after every edge outside reset.
   always @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < NB_DIGITS; i++) begin
            assert (int'(Cpt[i*DIGIT_W +: DIGIT_W]) < RADIX)
               else $error("digit %0d out of range: %0d", i, Cpt[i*DIGIT_W +: DIGIT_W]);
         end
      end
   end

endmodule

module cpt_updown_bcd_ndigits #(
   parameter int NB_DIGITS = 4,
   parameter int RADIX     = 10,
   parameter int DIGIT_W   = 4,
   parameter int SATURATE  = 0
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           Clear,
   input  logic                           Load,
   input  logic [NB_DIGITS*DIGIT_W-1:0]   LoadVal,
   input  logic                           En,
   input  logic                           Sens,
   output logic [NB_DIGITS*DIGIT_W-1:0]   Cpt,
   output logic                           Tc,
   output logic                           Ovf
);

   localparam int W = NB_DIGITS * DIGIT_W;
   localparam logic [DIGIT_W-1:0] DIG_MAX  = DIGIT_W'(RADIX - 1);
   localparam logic [DIGIT_W-1:0] DIG_ZERO = {DIGIT_W{1'b0}};
   localparam logic [DIGIT_W-1:0] DIG_ONE  = DIGIT_W'(1);

   logic [W-1:0] cpt_r;
   logic         ovf_r;
   logic [W-1:0] up_s;
   logic [W-1:0] dn_s;
   logic [W-1:0] load_clamp_s;
   logic         at_max_s;
   logic         at_min_s;

   // Digits beyond the modulus are forced to the largest legal digit.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
      if (d > DIG_MAX) begin
         return DIG_MAX;
      end else begin
         return d;
      end
   endfunction

   function automatic logic [DIGIT_W-1:0] inc_digit(input logic [DIGIT_W-1:0] d);
      if (d == DIG_MAX) begin
         return DIG_ZERO;
      end else begin
         return d + DIG_ONE;
      end
   endfunction

   function automatic logic [DIGIT_W-1:0] dec_digit(input logic [DIGIT_W-1:0] d);
      if (d == DIG_ZERO) begin
         return DIG_MAX;
      end else begin
         return d - DIG_ONE;
      end
   endfunction

   // Single-cycle ripple: a digit steps only when every lower digit is at its limit.
   always_comb begin
      logic                carry_v;
      logic                borrow_v;
      logic [DIGIT_W-1:0]  dig_v;
      up_s     = cpt_r;
      dn_s     = cpt_r;
      carry_v  = 1'b1;
      borrow_v = 1'b1;
      for (int i = 0; i < NB_DIGITS; i++) begin
         dig_v = cpt_r[i*DIGIT_W +: DIGIT_W];
         if (carry_v) begin
            up_s[i*DIGIT_W +: DIGIT_W] = inc_digit(dig_v);
         end else begin
            up_s[i*DIGIT_W +: DIGIT_W] = dig_v;
         end
         if (borrow_v) begin
            dn_s[i*DIGIT_W +: DIGIT_W] = dec_digit(dig_v);
         end else begin
            dn_s[i*DIGIT_W +: DIGIT_W] = dig_v;
         end
         carry_v  = carry_v & (dig_v == DIG_MAX);
         borrow_v = borrow_v & (dig_v == DIG_ZERO);
      end
      at_max_s = carry_v;
      at_min_s = borrow_v;
   end

   // Per-digit clamp of the load value.
   always_comb begin
      load_clamp_s = {W{1'b0}};
      for (int i = 0; i < NB_DIGITS; i++) begin
         load_clamp_s[i*DIGIT_W +: DIGIT_W] = clamp_digit(LoadVal[i*DIGIT_W +: DIGIT_W]);
      end
   end

   // Count state: Reset > Clear > Load > En; wrap already falls out of the ripple.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cpt_r <= {W{1'b0}};
         ovf_r <= 1'b0;
      end else if (Clear) begin
         cpt_r <= {W{1'b0}};
         ovf_r <= 1'b0;
      end else if (Load) begin
         cpt_r <= load_clamp_s;
         ovf_r <= 1'b0;
      end else if (En) begin
         if (!Sens) begin
            if (at_max_s) begin
               ovf_r <= 1'b1;
               cpt_r <= (SATURATE != 0) ? cpt_r : up_s;
            end else begin
               cpt_r <= up_s;
            end
         end else begin
            if (at_min_s) begin
               ovf_r <= 1'b1;
               cpt_r <= (SATURATE != 0) ? cpt_r : dn_s;
            end else begin
               cpt_r <= dn_s;
            end
         end
      end else begin
         cpt_r <= cpt_r;
         ovf_r <= ovf_r;
      end
   end

   // Terminal count is combinational so it can feed the next stage's En directly.
   always_comb begin
      if (En && !Reset && !Clear && !Load) begin
         Tc = Sens ? at_min_s : at_max_s;
      end else begin
         Tc = 1'b0;
      end
   end

   assign Cpt = cpt_r;
   assign Ovf = ovf_r;

   cpt_updown_bcd_ndigits_chk #(
      .NB_DIGITS (NB_DIGITS),
      .RADIX     (RADIX),
      .DIGIT_W   (DIGIT_W)
   ) u_chk (
      .Clk   (Clk),
      .Reset (Reset),
      .Cpt   (cpt_r)
   );

endmodule
